// File: rtl/demux_rr_par_pkg.sv
// -----------------------------------------------------------------------------
// demux_rr_par_pkg
// Shared phy package for the round-robin lane demultiplexer.
// Contents:
//   clog2()        - pointer width helper (never returns less than 1 bit)
//   ch_lsb()       - channel slicing rule: channel k occupies [k*BW +: BW]
//   PHY_*_DEFAULT  - default word width and channel count for the phy path
//   rel_kind_e     - what the group control decided to do at the next edge
// -----------------------------------------------------------------------------
package demux_rr_par_pkg;

  localparam int PHY_BW_DEFAULT  = 8;
  localparam int PHY_NCH_DEFAULT = 4;

  // Width needed to index 'value' channels; at least one bit so that a
  // 2-channel build still has a real pointer register.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  // Low bit of channel 'ch' inside a packed NCH*BW output bus.
  function automatic int ch_lsb(input int ch, input int bw);
    return ch * bw;
  endfunction

  // Group-level action taken at the coming clock edge.
  typedef enum logic [1:0] {
    REL_NONE    = 2'd0,  // keep filling (or idle)
    REL_FULL    = 2'd1,  // last channel written, release whole group
    REL_FLUSH   = 2'd2,  // release only the filled channels
    REL_DISCARD = 2'd3   // gap realign: drop partial group silently
  } rel_kind_e;

endpackage

// File: rtl/demux_rr_par_if.sv
// -----------------------------------------------------------------------------
// demux_rr_par_if
// Bus bundle between a word source and the round-robin demux.
// Signals:
//   data_in   [BW]      incoming serial word
//   valid_in            data_in valid this cycle
//   flush               emit current partial group at the next edge
//   data_out  [NCH*BW]  channel k at [k*BW +: BW]
//   valid_out [NCH]     per-channel one-cycle release pulse
//   ptr       [PTR_W]   channel the next valid word lands in
//   grp_cnt   [CNT_W]   completed full groups since reset
// Modports:
//   master - word source / observer (drives data_in, valid_in, flush)
//   slave  - the demux itself
// -----------------------------------------------------------------------------
interface demux_rr_par_if
  import demux_rr_par_pkg::*;
#(
  parameter int BW    = PHY_BW_DEFAULT,
  parameter int NCH   = PHY_NCH_DEFAULT,
  parameter int CNT_W = 16
);

  localparam int PTR_W = clog2(NCH);

  logic [BW-1:0]     data_in;
  logic              valid_in;
  logic              flush;
  logic [NCH*BW-1:0] data_out;
  logic [NCH-1:0]    valid_out;
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  grp_cnt;

  modport master (
    output data_in,
    output valid_in,
    output flush,
    input  data_out,
    input  valid_out,
    input  ptr,
    input  grp_cnt
  );

  modport slave (
    input  data_in,
    input  valid_in,
    input  flush,
    output data_out,
    output valid_out,
    output ptr,
    output grp_cnt
  );

endinterface

// File: rtl/demux_rr_ptr.sv
// -----------------------------------------------------------------------------
// demux_rr_ptr
// Round-robin write pointer, fill mask and group control decode.
// Ports:
//   clk_f, reset_L  block clock, async active-low reset
//   valid_in        a word is accepted this cycle (into channel ptr)
//   flush           release the partial group at this edge
//   ptr             channel the next valid word is written to
//   rel_mask        channels whose output register loads at this edge
//   grp_done        a full group completes at this edge
// -----------------------------------------------------------------------------
module demux_rr_ptr
  import demux_rr_par_pkg::*;
#(
  parameter int NCH          = PHY_NCH_DEFAULT,
  parameter bit ALIGN_ON_GAP = 1'b0,
  parameter int PTR_W        = clog2(NCH)
) (
  input  logic             clk_f,
  input  logic             reset_L,
  input  logic             valid_in,
  input  logic             flush,
  output logic [PTR_W-1:0] ptr,
  output logic [NCH-1:0]   rel_mask,
  output logic             grp_done
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NCH - 1);

  logic [NCH-1:0]   fill;
  logic [NCH-1:0]   fill_now;
  logic [NCH-1:0]   fill_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  rel_kind_e        rel_kind;

  // Fill mask as it stands once this cycle's word (if any) is counted, so a
  // flush on the same edge as a word includes that word.
  always_comb begin
    fill_now = fill;
    if (valid_in) fill_now[ptr] = 1'b1;
  end

  // Group decision. Full completion outranks flush (and so counts once even
  // when both happen together); flush outranks the gap realign.
  always_comb begin
    rel_kind = REL_NONE;
    if (valid_in && (ptr == LAST_PTR)) begin
      rel_kind = REL_FULL;
    end else if (flush && (fill_now != '0)) begin
      rel_kind = REL_FLUSH;
    end else if (ALIGN_ON_GAP && !valid_in && (fill != '0)) begin
      rel_kind = REL_DISCARD;
    end
  end

  // Every group action restarts the group at channel 0; otherwise a valid
  // word just advances the pointer with a natural power-of-two wrap.
  always_comb begin
    rel_mask = '0;
    grp_done = 1'b0;
    ptr_nxt  = ptr;
    fill_nxt = fill;
    case (rel_kind)
      REL_FULL: begin
        rel_mask = '1;
        grp_done = 1'b1;
        ptr_nxt  = '0;
        fill_nxt = '0;
      end
      REL_FLUSH: begin
        rel_mask = fill_now;
        ptr_nxt  = '0;
        fill_nxt = '0;
      end
      REL_DISCARD: begin
        ptr_nxt  = '0;
        fill_nxt = '0;
      end
      default: begin
        if (valid_in) begin
          ptr_nxt  = ptr + PTR_W'(1);
          fill_nxt = fill_now;
        end
      end
    endcase
  end

  // Pointer and fill state.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      ptr  <= '0;
      fill <= '0;
    end else begin
      ptr  <= ptr_nxt;
      fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/demux_rr_par.sv
// -----------------------------------------------------------------------------
// demux_rr_par
// Parametrised 1:NCH round-robin lane demultiplexer. Consecutive valid words
// are dealt into NCH staging registers and each completed (or flushed) group
// is released to the channel outputs in one aligned cycle.
// Ports:
//   clk_f    block clock, rising edge
//   reset_L  asynchronous active-low reset
//   bus      demux_rr_par_if.slave: data_in/valid_in/flush in,
//            data_out/valid_out/ptr/grp_cnt out
// -----------------------------------------------------------------------------
module demux_rr_par
  import demux_rr_par_pkg::*;
#(
  parameter int BW           = PHY_BW_DEFAULT,
  parameter int NCH          = PHY_NCH_DEFAULT,
  parameter bit ALIGN_ON_GAP = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic           clk_f,
  input  logic           reset_L,
  demux_rr_par_if.slave  bus
);

  localparam int PTR_W = clog2(NCH);

  logic [PTR_W-1:0]  ptr;
  logic [NCH-1:0]    rel_mask;
  logic              grp_done;
  logic [BW-1:0]     stage    [NCH];
  logic [BW-1:0]     rel_word [NCH];
  logic [NCH*BW-1:0] data_q;
  logic [NCH-1:0]    valid_q;
  logic [CNT_W-1:0]  grp_cnt_q;

  demux_rr_ptr #(
    .NCH          (NCH),
    .ALIGN_ON_GAP (ALIGN_ON_GAP),
    .PTR_W        (PTR_W)
  ) u_ptr (
    .clk_f    (clk_f),
    .reset_L  (reset_L),
    .valid_in (bus.valid_in),
    .flush    (bus.flush),
    .ptr      (ptr),
    .rel_mask (rel_mask),
    .grp_done (grp_done)
  );

  // Staging registers. A staged word is only ever read while its fill bit is
  // set, so stale contents after a release or discard are harmless.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < NCH; k++) stage[k] <= '0;
    end else if (bus.valid_in) begin
      stage[ptr] <= bus.data_in;
    end
  end

  // The word arriving this cycle bypasses its staging register so the
  // completing word lands in the outputs on the same edge.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      rel_word[k] = stage[k];
      if (bus.valid_in && (ptr == PTR_W'(k))) rel_word[k] = bus.data_in;
    end
  end

  // Output registers only move on a release; unreleased channels keep their
  // last values and valid_out is a one-cycle pulse.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      data_q    <= '0;
      valid_q   <= '0;
      grp_cnt_q <= '0;
    end else begin
      valid_q <= rel_mask;
      for (int k = 0; k < NCH; k++) begin
        if (rel_mask[k]) data_q[ch_lsb(k, BW) +: BW] <= rel_word[k];
      end
      if (grp_done) grp_cnt_q <= grp_cnt_q + CNT_W'(1);
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.ptr       = ptr;
  assign bus.grp_cnt   = grp_cnt_q;

endmodule

// File: tb/tb_demux_rr_par.sv
// -----------------------------------------------------------------------------
// tb_demux_rr_par
// Directed bench for demux_rr_par with BW=8, NCH=4. Three instances:
//   dut0 - ALIGN_ON_GAP=0, CNT_W=16
//   dut1 - ALIGN_ON_GAP=1, CNT_W=16
//   dut2 - ALIGN_ON_GAP=0, CNT_W=2
// Expected releases are queued when the releasing word is driven and must
// appear exactly one edge later.
// -----------------------------------------------------------------------------
module tb_demux_rr_par;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  logic clk_f;
  logic reset_L;

  logic [7:0]  d_in    [3];
  logic        v_in    [3];
  logic        fl      [3];
  logic [31:0] d_out   [3];
  logic [3:0]  v_out   [3];
  logic [1:0]  p_out   [3];
  logic [15:0] cnt_out [3];

  exp_t sb[$];
  int   compared;
  int   mismatched;

  demux_rr_par_if #(.BW(8), .NCH(4), .CNT_W(16)) if0 ();
  demux_rr_par_if #(.BW(8), .NCH(4), .CNT_W(16)) if1 ();
  demux_rr_par_if #(.BW(8), .NCH(4), .CNT_W(2))  if2 ();

  demux_rr_par #(.BW(8), .NCH(4), .ALIGN_ON_GAP(1'b0), .CNT_W(16)) dut0 (
    .clk_f(clk_f), .reset_L(reset_L), .bus(if0.slave));
  demux_rr_par #(.BW(8), .NCH(4), .ALIGN_ON_GAP(1'b1), .CNT_W(16)) dut1 (
    .clk_f(clk_f), .reset_L(reset_L), .bus(if1.slave));
  demux_rr_par #(.BW(8), .NCH(4), .ALIGN_ON_GAP(1'b0), .CNT_W(2)) dut2 (
    .clk_f(clk_f), .reset_L(reset_L), .bus(if2.slave));

  assign if0.data_in  = d_in[0];
  assign if0.valid_in = v_in[0];
  assign if0.flush    = fl[0];
  assign if1.data_in  = d_in[1];
  assign if1.valid_in = v_in[1];
  assign if1.flush    = fl[1];
  assign if2.data_in  = d_in[2];
  assign if2.valid_in = v_in[2];
  assign if2.flush    = fl[2];

  assign d_out[0]   = if0.data_out;
  assign v_out[0]   = if0.valid_out;
  assign p_out[0]   = if0.ptr;
  assign cnt_out[0] = if0.grp_cnt;
  assign d_out[1]   = if1.data_out;
  assign v_out[1]   = if1.valid_out;
  assign p_out[1]   = if1.ptr;
  assign cnt_out[1] = if1.grp_cnt;
  assign d_out[2]   = if2.data_out;
  assign v_out[2]   = if2.valid_out;
  assign p_out[2]   = if2.ptr;
  assign cnt_out[2] = {14'b0, if2.grp_cnt};

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_f = 1'b0;
    forever #5 clk_f = ~clk_f;
  end

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the release that the next driven word/flush must cause.
  task automatic expectPulse(input logic [3:0] mask, input logic [31:0] data, input logic [15:0] cnt);
    exp_t e;
    e.mask = mask;
    e.data = data;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  // After an edge: a pulse must be present exactly when one was queued.
  task automatic checkOutput(input int idx);
    exp_t       e;
    logic [3:0] em;
    em = 4'b0000;
    if (sb.size() != 0) em = sb[0].mask;
    checkVal($sformatf("dut%0d valid_out", idx), {28'b0, v_out[idx]}, {28'b0, em});
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkVal($sformatf("dut%0d data_out", idx), d_out[idx], e.data);
      checkVal($sformatf("dut%0d grp_cnt at release", idx), {16'b0, cnt_out[idx]}, {16'b0, e.cnt});
    end
  endtask

  // Drive one cycle of inputs, take the edge, sample 1 time unit later.
  task automatic applyStimulus(input int idx, input logic v, input logic [7:0] d, input logic f);
    v_in[idx] = v;
    d_in[idx] = d;
    fl[idx]   = f;
    @(posedge clk_f);
    #1;
    v_in[idx] = 1'b0;
    fl[idx]   = 1'b0;
    checkOutput(idx);
  endtask

  logic [31:0] grpWord;
  logic [7:0]  w;
  int          cntSeq [5];

  initial begin
    compared   = 0;
    mismatched = 0;
    cntSeq     = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 3; i++) begin
      d_in[i] = 8'h00;
      v_in[i] = 1'b0;
      fl[i]   = 1'b0;
    end

    // Reset: a real falling edge, release between clock edges.
    reset_L = 1'b1;
    #2 reset_L = 1'b0;
    #6;
    checkVal("reset data_out", d_out[0], 32'h0);
    checkVal("reset valid_out", {28'b0, v_out[0]}, 32'h0);
    checkVal("reset ptr", {30'b0, p_out[0]}, 32'h0);
    checkVal("reset grp_cnt", {16'b0, cnt_out[0]}, 32'h0);
    #4 reset_L = 1'b1;
    @(posedge clk_f);
    #1;

    // Two back-to-back full groups on dut0.
    $display("[TB] back-to-back groups");
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) expectPulse(4'b1111, 32'h44332211, 16'd1);
      if (i == 8) expectPulse(4'b1111, 32'h88776655, 16'd2);
      applyStimulus(0, 1'b1, 8'(i * 17), 1'b0);
    end
    checkVal("grp_cnt after 2 groups", {16'b0, cnt_out[0]}, 32'd2);
    checkVal("ptr after 2 groups", {30'b0, p_out[0]}, 32'd0);

    // Partial flush with no word this cycle.
    $display("[TB] partial flush");
    applyStimulus(0, 1'b1, 8'hA1, 1'b0);
    applyStimulus(0, 1'b1, 8'hA2, 1'b0);
    checkVal("ptr before flush", {30'b0, p_out[0]}, 32'd2);
    expectPulse(4'b0011, 32'h8877A2A1, 16'd2);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    checkVal("ptr after flush", {30'b0, p_out[0]}, 32'd0);
    checkVal("grp_cnt after flush", {16'b0, cnt_out[0]}, 32'd2);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    checkVal("data hold after empty flush", d_out[0], 32'h8877A2A1);

    // Gap with pointer hold.
    $display("[TB] gap hold");
    applyStimulus(0, 1'b1, 8'h01, 1'b0);
    applyStimulus(0, 1'b1, 8'h02, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 8'h00, 1'b0);
    checkVal("ptr held over gap", {30'b0, p_out[0]}, 32'd2);
    applyStimulus(0, 1'b1, 8'h03, 1'b0);
    expectPulse(4'b1111, 32'h04030201, 16'd3);
    applyStimulus(0, 1'b1, 8'h04, 1'b0);

    // Gap realign on dut1.
    $display("[TB] gap realign");
    applyStimulus(1, 1'b1, 8'h01, 1'b0);
    applyStimulus(1, 1'b1, 8'h02, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    checkVal("align ptr after gap", {30'b0, p_out[1]}, 32'd0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 8'h03, 1'b0);
    applyStimulus(1, 1'b1, 8'h04, 1'b0);
    checkVal("align ptr after 03,04", {30'b0, p_out[1]}, 32'd2);
    applyStimulus(1, 1'b1, 8'h05, 1'b0);
    expectPulse(4'b1111, 32'h06050403, 16'd1);
    applyStimulus(1, 1'b1, 8'h06, 1'b0);
    applyStimulus(1, 1'b1, 8'h0A, 1'b0);
    expectPulse(4'b0001, 32'h0605040A, 16'd1);
    applyStimulus(1, 1'b0, 8'h00, 1'b1);
    checkVal("align ptr after gap+flush", {30'b0, p_out[1]}, 32'd0);

    // Asynchronous reset mid-group.
    $display("[TB] async reset mid-group");
    applyStimulus(0, 1'b1, 8'h31, 1'b0);
    applyStimulus(0, 1'b1, 8'h32, 1'b0);
    applyStimulus(0, 1'b1, 8'h33, 1'b0);
    #3 reset_L = 1'b0;
    #1;
    checkVal("async reset data_out", d_out[0], 32'h0);
    checkVal("async reset valid_out", {28'b0, v_out[0]}, 32'h0);
    checkVal("async reset ptr", {30'b0, p_out[0]}, 32'h0);
    checkVal("async reset grp_cnt", {16'b0, cnt_out[0]}, 32'h0);
    checkVal("async reset dut1 grp_cnt", {16'b0, cnt_out[1]}, 32'h0);
    #10 reset_L = 1'b1;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) expectPulse(4'b1111, 32'h44434241, 16'd1);
      applyStimulus(0, 1'b1, 8'(8'h40 + i), 1'b0);
    end
    checkVal("grp_cnt after reset group", {16'b0, cnt_out[0]}, 32'd1);

    // Narrow counter wrap on dut2.
    $display("[TB] counter wrap");
    for (int g = 0; g < 5; g++) begin
      grpWord = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w = 8'(g * 16 + k + 1);
        grpWord[k*8 +: 8] = w;
        if (k == 3) expectPulse(4'b1111, grpWord, 16'(cntSeq[g]));
        applyStimulus(2, 1'b1, w, 1'b0);
      end
    end

    // Flush together with the completing word counts once.
    $display("[TB] flush on completing word");
    applyStimulus(2, 1'b1, 8'hC1, 1'b0);
    applyStimulus(2, 1'b1, 8'hC2, 1'b0);
    applyStimulus(2, 1'b1, 8'hC3, 1'b0);
    expectPulse(4'b1111, 32'hC4C3C2C1, 16'd2);
    applyStimulus(2, 1'b1, 8'hC4, 1'b1);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    checkVal("grp_cnt after flush+complete", {16'b0, cnt_out[2]}, 32'd2);
    checkVal("ptr after flush+complete", {30'b0, p_out[2]}, 32'd0);

    checkVal("scoreboard drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
